// File: rtl/m68k_fpga_bus_slave_pkg.sv
// Shared types and constants for the 68040-side FPGA register window slave.
package m68k_fpga_bus_slave_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [ADDR_W-1:0] FPGA_BASE_ADDR   = 32'hFFF0_0000;
  localparam logic [ADDR_W-1:0] FPGA_DECODE_MASK = 32'hFFFF_FFF0;
  localparam logic [REG_AW-1:0] FPGA_IRQ_REG_OFS = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STROBE,
    ST_BLANK,
    ST_WAIT,
    ST_TERM,
    ST_ERR
  } state_t;

  // Big-endian lane pick: offset 0 is the most significant byte of the bus.
  function automatic logic [BYTE_W-1:0] byte_lane_sel(input logic [DATA_W-1:0] d,
                                                      input logic [1:0]        lane);
    logic [BYTE_W-1:0] b;
    case (lane)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/m68k_byte_lane_sel.sv
// Combinational 32->8 write-lane mux indexed by the low address bits.
module m68k_byte_lane_sel
  import m68k_fpga_bus_slave_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        lane,
  output logic [BYTE_W-1:0] byte_c
);

  assign byte_c = byte_lane_sel(d, lane);

endmodule

// File: rtl/m68k_fpga_bus_slave.sv
// 68040 bus slave for the FPGA register window: decode, strobe, wait for ack, end with TA or TEA.
module m68k_fpga_bus_slave
  import m68k_fpga_bus_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = FPGA_BASE_ADDR,
  parameter logic [ADDR_W-1:0] DECODE_MASK = FPGA_DECODE_MASK,
  parameter int unsigned       TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ts_n,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d_in,
  output logic [DATA_W-1:0] cpu_d_out,
  output logic              cpu_d_oe,
  output logic              cpu_ta_n,
  output logic              cpu_tea_n,
  output logic              fpga_stb,
  input  logic              fpga_ack,
  output logic [REG_AW-1:0] fpga_addr,
  output logic [BYTE_W-1:0] fpga_data,
  input  logic [DATA_W-1:0] fpga_odata,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               rw_q, rw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0]  addr_d;
  logic [BYTE_W-1:0]  data_d;
  logic [DATA_W-1:0]  dout_d;
  logic               stb_d, ta_n_d, tea_n_d, oe_d, busy_d;
  logic               hit_c;
  logic [BYTE_W-1:0]  lane_byte_c;

  assign hit_c = ((cpu_a & DECODE_MASK) == (BASE_ADDR & DECODE_MASK));

  m68k_byte_lane_sel u_lane_sel (
    .d      (cpu_d_in),
    .lane   (fpga_addr[1:0]),
    .byte_c (lane_byte_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      fpga_addr <= '0;
      fpga_data <= '0;
      cpu_d_out <= '0;
      fpga_stb  <= 1'b0;
      cpu_ta_n  <= 1'b1;
      cpu_tea_n <= 1'b1;
      cpu_d_oe  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      fpga_addr <= addr_d;
      fpga_data <= data_d;
      cpu_d_out <= dout_d;
      fpga_stb  <= stb_d;
      cpu_ta_n  <= ta_n_d;
      cpu_tea_n <= tea_n_d;
      cpu_d_oe  <= oe_d;
      busy      <= busy_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    addr_d  = fpga_addr;
    data_d  = fpga_data;
    dout_d  = cpu_d_out;

    case (state_q)
      ST_IDLE: begin
        if (!cpu_ts_n && hit_c) begin
          addr_d  = cpu_a[REG_AW-1:0];
          rw_d    = cpu_rw;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        data_d  = lane_byte_c;
        state_d = ST_STROBE;
      end
      ST_STROBE: state_d = ST_BLANK;
      // Ack is still high from the previous access here, so it is not looked at.
      ST_BLANK: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fpga_ack) begin
          dout_d  = fpga_odata;
          state_d = ST_TERM;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TERM: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    stb_d   = (state_d == ST_STROBE);
    ta_n_d  = (state_d != ST_TERM);
    tea_n_d = (state_d != ST_ERR);
    oe_d    = (state_d == ST_TERM) && rw_d;
    busy_d  = (state_d != ST_IDLE);
  end

endmodule

// File: doc/m68k_fpga_bus_slave.md
Name: m68k_fpga_bus_slave

Overview:
- Upstream stage of the FPGA register/interrupt interface.
- Watches the 68040 bus. Decodes accesses to the FPGA register window and latches the address and write byte.
- Issues a one-cycle strobe to the register interface and waits for its ack. Ends the CPU cycle with TA, or with TEA on timeout.
- Returns read data from the register interface onto the CPU data bus.

Parameters:
- BASE_ADDR, 32'hFFF0_0000, base of the FPGA register window.
- DECODE_MASK, 32'hFFFF_FFF0, address bits compared against BASE_ADDR (window = 16 bytes).
- TIMEOUT, 16, cycles to wait in WAIT before TEA; 0 disables the timeout.

Ports:
- clk  in  1  system clock (CPU BCLK domain).
- rst  in  1  asynchronous, active-high reset.
- cpu_ts_n  in  1  68040 transfer start, active-low, one-cycle pulse.
- cpu_rw  in  1  1 = read, 0 = write; sampled with TS.
- cpu_a  in  32  CPU address; sampled with TS.
- cpu_d_in  in  32  CPU write data; valid the cycle after TS.
- cpu_d_out  out  32  read data to the CPU.
- cpu_d_oe  out  1  data bus output enable.
- cpu_ta_n  out  1  transfer acknowledge, active-low.
- cpu_tea_n  out  1  transfer error acknowledge, active-low.
- fpga_stb  out  1  one-cycle strobe to the register interface.
- fpga_ack  in  1  level ack from the register interface; sticky-high until it sees the next strobe.
- fpga_addr  out  4  register byte address, cpu_a[3:0].
- fpga_data  out  8  write byte.
- fpga_odata  in  32  read data from the register interface.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, fpga_stb=0, cpu_ta_n=1, cpu_tea_n=1, cpu_d_oe=0, cpu_d_out=0, fpga_addr=0, fpga_data=0, timeout counter=0. Reset mid-transaction abandons the cycle with no TA and no TEA.
- hit = ((cpu_a & DECODE_MASK) == (BASE_ADDR & DECODE_MASK)).
- All outputs are registered.
- States:
  - IDLE: on cpu_ts_n=0 and hit, latch cpu_a[3:0] into fpga_addr and cpu_rw into rw_q, then go to DATA. TS with no hit is ignored.
  - DATA: latch the write byte from cpu_d_in, lane chosen by a[1:0]:
    - 0 selects D[31:24]
    - 1 selects D[23:16]
    - 2 selects D[15:8]
    - 3 selects D[7:0]
    - For reads the latch happens but is don't-care.
    - Next state STROBE.
  - STROBE: fpga_stb=1 for exactly this cycle. Next state BLANK.
  - BLANK: ignore fpga_ack, which is stale-high from the previous access. Clear the counter. Next state WAIT.
  - WAIT:
    - If fpga_ack=1: capture fpga_odata into cpu_d_out and go to TERM.
    - Else increment the counter. When counter == TIMEOUT-1 (TIMEOUT != 0), go to ERR.
    - If ack and timeout coincide, ack wins.
  - TERM: cpu_ta_n=0 for one cycle. cpu_d_oe=1 in this cycle only if rw_q=1. Next state IDLE.
  - ERR: cpu_tea_n=0 for one cycle, cpu_d_oe=0. Next state IDLE.
- fpga_addr and fpga_data stay stable from STROBE until the next accepted TS. The register interface uses them combinationally during its wait state.
- TS asserted outside IDLE is ignored; the 68040 does not pipeline.
- Back-to-back: a TS in the cycle after TERM/ERR is accepted, since the state is already IDLE.
- Minimum latency, TS sampled at edge N: strobe high cycle N+2, TA low cycle N+5 when the ack is already high at N+4.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DATA, STROBE, BLANK, WAIT, TERM, ERR);
  - the byte-lane select function;
  - FPGA register window constants (BASE_ADDR, DECODE_MASK, register offset 4'h4 for the interrupt register).
- Natural single sub-module: m68k_byte_lane_sel, a combinational 32→8 lane mux indexed by a[1:0]. Everything else stays in one FSM module.

Test Plan:
- Write, a=FFF0_0004, d_in=0000_0500 (byte in lane D[15:8] for a[1:0]=0? no): use a=FFF0_0004, D[31:24]=8'h05. Expect fpga_addr=4, fpga_data=8'h05, fpga_stb one cycle at N+2. With fpga_ack rising at N+3 and held, TA low exactly at N+5, cpu_d_oe=0.
- Read, a=FFF0_0003, fpga_odata=DEAD_BEEF, ack held high from a previous access. BLANK ignores the stale ack. Expect cpu_d_out=DEAD_BEEF and cpu_d_oe=1 only in the TA cycle.
- Miss, a=0000_1000 with TS → no strobe, no TA, no TEA; busy stays 0.
- Timeout, TIMEOUT=16, ack held 0 → TEA low one cycle 16 cycles after entering WAIT, no TA. Repeat with TIMEOUT=0 → waits indefinitely; a later ack gives TA.
- Reset mid-op: assert rst during WAIT → ta_n and tea_n both stay 1, state IDLE; the next hit TS runs normally.
- Back-to-back writes to 4 and 5, second TS one cycle after the first TA → two strobes, two TAs. fpga_data lanes D[31:24] then D[23:16].
